// File: rtl/reg_wr_burst_decoder.sv
// Register-file write-enable generator: decodes bursts of consecutive register
// indices into registered one-hot write enables, with stall, abort and optional r0 masking.
module reg_wr_burst_decoder #(
    parameter int unsigned ADDR_W       = 3,
    parameter int unsigned LEN_W        = 3,
    parameter int unsigned PROTECT_ZERO = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [LEN_W-1:0]       req_len,
    input  logic                   enable,
    input  logic                   abort,
    output logic [2**ADDR_W-1:0]   wr_en,
    output logic [ADDR_W-1:0]      wr_idx,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned NUM_REGS = 2**ADDR_W;

    typedef enum logic {StIdle, StBurst} state_e;

    state_e              state;
    logic [ADDR_W-1:0]   cur_addr;
    logic [LEN_W-1:0]    remaining;
    logic [NUM_REGS-1:0] dec;

    assign req_ready = (state == StIdle) & ~abort;
    assign busy      = (state == StBurst);

    // The zero slot still takes a beat when masked; only its enable line is suppressed.
    always_comb begin
        dec           = '0;
        dec[cur_addr] = 1'b1;
        if (PROTECT_ZERO != 0) begin
            dec[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StIdle;
            wr_en     <= '0;
            wr_idx    <= '0;
            done      <= 1'b0;
            cur_addr  <= '0;
            remaining <= '0;
        end else begin
            case (state)
                StIdle: begin
                    wr_en <= '0;
                    done  <= 1'b0;
                    if (req_valid && req_ready) begin
                        cur_addr  <= req_addr;
                        remaining <= req_len;
                        state     <= StBurst;
                    end
                end
                StBurst: begin
                    if (abort) begin
                        state <= StIdle;
                        wr_en <= '0;
                        done  <= 1'b0;
                    end else if (!enable) begin
                        wr_en <= '0;
                        done  <= 1'b0;
                    end else begin
                        wr_en    <= dec;
                        wr_idx   <= cur_addr;
                        cur_addr <= cur_addr + 1'b1;
                        if (remaining == '0) begin
                            done  <= 1'b1;
                            state <= StIdle;
                        end else begin
                            remaining <= remaining - 1'b1;
                            done      <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                    wr_en <= '0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_wr_burst_decoder.sv
// Bench for reg_wr_burst_decoder: a queue-of-beats model checked every cycle against
// two instances (r0 writable and r0 protected), plus directed literal expectations.
module tb_reg_wr_burst_decoder;

    logic       clk = 1'b0;
    logic       rst_n, req_valid, enable, abort;
    logic [2:0] req_addr, req_len;

    logic       req_ready, busy, done;
    logic [7:0] wr_en;
    logic [2:0] wr_idx;
    logic       pz_req_ready, pz_busy, pz_done;
    logic [7:0] pz_wr_en;
    logic [2:0] pz_wr_idx;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_wr_burst_decoder #(.ADDR_W(3), .LEN_W(3), .PROTECT_ZERO(0)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len), .enable(enable), .abort(abort),
        .wr_en(wr_en), .wr_idx(wr_idx), .busy(busy), .done(done)
    );

    reg_wr_burst_decoder #(.ADDR_W(3), .LEN_W(3), .PROTECT_ZERO(1)) dut_pz (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(pz_req_ready),
        .req_addr(req_addr), .req_len(req_len), .enable(enable), .abort(abort),
        .wr_en(pz_wr_en), .wr_idx(pz_wr_idx), .busy(pz_busy), .done(pz_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted burst becomes a queue of register indices; each enabled
    // cycle writes the head of the queue, done marks the beat that empties it.
    int         beats[$];
    logic [7:0] m_wr   = '0;
    logic [2:0] m_idx  = '0;
    logic       m_done = 1'b0;

    always @(posedge clk) begin
        logic s_rst, s_valid, s_en, s_abort;
        logic [2:0] s_addr, s_len;
        int a;
        s_rst = rst_n; s_valid = req_valid; s_en = enable; s_abort = abort;
        s_addr = req_addr; s_len = req_len;
        m_wr   = '0;
        m_done = 1'b0;
        if (!s_rst) begin
            beats.delete();
            m_idx = '0;
        end else if (beats.size() == 0) begin
            if (s_valid && !s_abort) begin
                for (int i = 0; i <= int'(s_len); i++) beats.push_back((int'(s_addr) + i) % 8);
            end
        end else if (s_abort) begin
            beats.delete();
        end else if (s_en) begin
            a      = beats.pop_front();
            m_wr   = 8'(1 << a);
            m_idx  = 3'(a);
            m_done = (beats.size() == 0);
        end
        #1;
        chk("model wr_en", wr_en, m_wr);
        chk("model wr_idx", wr_idx, m_idx);
        chk("model done", done, m_done);
        chk("model busy", busy, beats.size() != 0);
        chk("model req_ready", req_ready, (beats.size() == 0) && !abort);
        chk("model pz wr_en", pz_wr_en, m_wr & 8'hFE);
        chk("model pz wr_idx", pz_wr_idx, m_idx);
        chk("model pz done", pz_done, m_done);
        chk("model pz busy", pz_busy, beats.size() != 0);
        chk("model pz req_ready", pz_req_ready, (beats.size() == 0) && !abort);
    end

    // Advance one edge and check the hand-computed outputs of the plain instance.
    task automatic tick(input string name, input logic [7:0] exp_wr, input logic exp_done);
        @(posedge clk);
        #2;
        chk({name, " wr_en"}, wr_en, exp_wr);
        chk({name, " done"}, done, exp_done);
    endtask

    task automatic request(input logic [2:0] addr, input logic [2:0] len);
        req_valid = 1'b1; req_addr = addr; req_len = len;
        tick("accept", 8'h00, 1'b0);
        chk("accept busy", busy, 1'b1);
        req_valid = 1'b0; req_addr = 3'd0; req_len = 3'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; enable = 1'b1; abort = 1'b0;
        req_addr = 3'd0; req_len = 3'd0;
        repeat (3) tick("reset", 8'h00, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset wr_idx", wr_idx, 3'd0);
        rst_n = 1'b1;
        tick("idle", 8'h00, 1'b0);

        // Abort in idle blocks acceptance.
        req_valid = 1'b1; req_addr = 3'd4; abort = 1'b1;
        #1 chk("abort idle ready", req_ready, 1'b0);
        tick("abort idle", 8'h00, 1'b0);
        chk("abort idle busy", busy, 1'b0);
        req_valid = 1'b0; abort = 1'b0;

        // Single write.
        request(3'd5, 3'd0);
        tick("single", 8'h20, 1'b1);
        chk("single wr_idx", wr_idx, 3'd5);
        tick("single after", 8'h00, 1'b0);
        chk("single ready", req_ready, 1'b1);

        // Wrap-around burst; r0-protected instance suppresses the 0x01 beat.
        request(3'd6, 3'd3);
        tick("wrap b0", 8'h40, 1'b0);
        chk("wrap busy0", busy, 1'b1);
        tick("wrap b1", 8'h80, 1'b0);
        chk("wrap busy1", busy, 1'b1);
        tick("wrap b2", 8'h01, 1'b0);
        chk("wrap pz b2 wr_en", pz_wr_en, 8'h00);
        chk("wrap pz b2 wr_idx", pz_wr_idx, 3'd0);
        chk("wrap busy2", busy, 1'b1);
        tick("wrap b3", 8'h02, 1'b1);
        chk("wrap busy3", busy, 1'b0);
        tick("wrap gap", 8'h00, 1'b0);

        // Stall for two cycles after the first beat.
        request(3'd2, 3'd2);
        tick("stall b0", 8'h04, 1'b0);
        enable = 1'b0;
        tick("stall s0", 8'h00, 1'b0);
        tick("stall s1", 8'h00, 1'b0);
        chk("stall busy", busy, 1'b1);
        enable = 1'b1;
        tick("stall b1", 8'h08, 1'b0);
        tick("stall b2", 8'h10, 1'b1);
        tick("stall gap", 8'h00, 1'b0);

        // Abort on the third burst cycle.
        request(3'd0, 3'd7);
        tick("abort b0", 8'h01, 1'b0);
        chk("abort pz b0", pz_wr_en, 8'h00);
        tick("abort b1", 8'h02, 1'b0);
        abort = 1'b1;
        tick("abort cut", 8'h00, 1'b0);
        chk("abort busy", busy, 1'b0);
        abort = 1'b0;
        #1 chk("abort ready", req_ready, 1'b1);
        tick("abort gap", 8'h00, 1'b0);

        // Protected r0: burst 7,0.
        request(3'd7, 3'd1);
        tick("pz b0", 8'h80, 1'b0);
        chk("pz b0 wr_en", pz_wr_en, 8'h80);
        tick("pz b1", 8'h01, 1'b1);
        chk("pz b1 wr_en", pz_wr_en, 8'h00);
        chk("pz b1 wr_idx", pz_wr_idx, 3'd0);
        chk("pz b1 done", pz_done, 1'b1);
        tick("pz gap", 8'h00, 1'b0);

        // Synchronous reset in the middle of a 4-beat burst.
        request(3'd1, 3'd3);
        tick("rst b0", 8'h02, 1'b0);
        rst_n = 1'b0;
        tick("rst cut", 8'h00, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst wr_idx", wr_idx, 3'd0);
        rst_n = 1'b1;
        tick("rst idle", 8'h00, 1'b0);
        request(3'd3, 3'd0);
        tick("rst new", 8'h08, 1'b1);
        tick("rst end", 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
